lsu_mem_ctrl: RTL and testbench

Load/store sequencer between the RV32I pipeline's memory stage and a word-only, handshaked data memory. It turns byte, halfword and word requests into word-aligned memory transactions. Sub-word stores use read-modify-write. For loads it returns the raw memory word together with the size/sign mask and byte offset that the downstream load-data extraction logic consumes. The pipeline stalls on `busy_o`.

---
 rtl/lsu_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: turns byte/half/word requests into word-aligned memory transactions, using read-modify-write for sub-word stores.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses respond with rsp_err_o instead of being force-aligned.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [2:0]        req_mask_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [2:0]        rsp_mask_o,
    output logic [1:0]        rsp_offset_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    // state | meaning
    // IDLE  | waiting for a request; only state that accepts one
    // RD    | word read in flight (load, or first half of a sub-word store)
    // MERGE | insert store bytes into the captured read word
    // WR    | word write in flight
    // RESP  | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        mask_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [31:0]       wr_word_q;
    logic [31:0]       rsp_rdata_q;
    logic [31:0]       merged;

    logic       accept;
    logic       req_byte;
    logic       req_word;
    logic       trap;
    logic [1:0] req_off;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign req_byte    = (req_mask_i[1:0] == 2'b00);
    assign req_word    = req_mask_i[1];

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;

    assign trap    = (req_word && (req_addr_i[1:0] != 2'b00))
                   || (!req_byte && !req_word && req_addr_i[0]);
    assign req_off = req_addr_i[1:0];
    assign rsp_err_o = rsp_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= trap;
        end
    end
`else
    // Offset bits below the access size are dropped so the access is naturally aligned.
    assign trap    = 1'b0;
    assign req_off = req_word ? 2'b00
                   : (req_byte ? req_addr_i[1:0] : {req_addr_i[1], 1'b0});
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (trap) begin
                        state_d = RESP;
                    end else if (req_we_i && req_word) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    state_d = we_q ? MERGE : RESP;
                end
            end
            MERGE: state_d = WR;
            WR: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        merged = wr_word_q;
        if (mask_q[1:0] == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // wr_word_q holds the store word directly for word stores, else the read word until MERGE rewrites it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            mask_q      <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0;
            wr_word_q   <= 32'h0;
            rsp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q        <= req_we_i;
                addr_q      <= {req_addr_i[ADDR_W-1:2], 2'b00};
                mask_q      <= req_mask_i;
                off_q       <= req_off;
                wdata_q     <= req_wdata_i[15:0];
                wr_word_q   <= req_wdata_i;
                rsp_rdata_q <= 32'h0;
            end
            if ((state_q == RD) && mem_ack_i) begin
                if (we_q) begin
                    wr_word_q <= mem_rdata_i;
                end else begin
                    rsp_rdata_q <= mem_rdata_i;
                end
            end
            if (state_q == MERGE) begin
                wr_word_q <= merged;
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = (state_q == RD) || (state_q == WR);
    assign mem_we_o     = (state_q == WR);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = (state_q == WR) ? wr_word_q : 32'h0;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_mask_o   = mask_q;
    assign rsp_offset_o = off_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus random loads/stores against a byte-lane memory model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [2:0]  req_mask_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [2:0]  rsp_mask_o;
    logic [1:0]  rsp_offset_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    always #5 clk_i = ~clk_i;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_mask_i  (req_mask_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_mask_o  (rsp_mask_o),
        .rsp_offset_o(rsp_offset_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // memory model: 4 KiB, word indexed by addr[11:2]
    logic [31:0] mem [1024];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_rd_addr = 32'h0;
    logic        req_prev = 1'b0;
    logic        ack_prev = 1'b0;
    logic [63:0] bus_prev = 64'h0;
    logic        we_prev = 1'b0;

    always @(negedge clk_i) begin
        if (req_prev && !ack_prev && mem_req_o) begin
            check_val("mem_bus_stable", {mem_addr_o, mem_wdata_o}, bus_prev);
            check_val("mem_we_stable", mem_we_o, we_prev);
        end
        if (mem_req_o) begin
            if (wcnt >= wait_cfg) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o[11:2]];
                wcnt        = 0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                wcnt++;
            end
        end else begin
            mem_ack_i   = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            wcnt        = 0;
        end
        req_prev = mem_req_o;
        ack_prev = mem_ack_i;
        bus_prev = {mem_addr_o, mem_wdata_o};
        we_prev  = mem_we_o;
    end

    always @(posedge clk_i) begin
        if (mem_req_o && mem_ack_i && !rst_i) begin
            if (mem_we_o) begin
                mem[mem_addr_o[11:2]] = mem_wdata_o;
                last_wr_addr = mem_addr_o;
                n_wr++;
            end else begin
                last_rd_addr = mem_addr_o;
                n_rd++;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] mask,
                          input logic [31:0] wdata);
        int          sz, off, eff, idx, lat, k, rd0, wr0;
        bit          trapped, exp_rd, exp_wr;
        logic [31:0] old_w, new_w, exp_rdata;
        sz  = (mask[1:0] == 2'b00) ? 1 : ((mask[1:0] == 2'b01) ? 2 : 4);
        off = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        trapped = (off % sz) != 0;
        eff     = off;
`else
        trapped = 1'b0;
        eff     = off - (off % sz);
`endif
        k = 0;
        @(negedge clk_i);
        while (!req_ready_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 20) check_val("ready_timeout", 0, 1);
        idx   = int'(addr[11:2]);
        old_w = mem[idx];
        new_w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (b >= eff && b < eff + sz) new_w[b*8 +: 8] = wdata[(b-eff)*8 +: 8];
        end
        exp_rd    = !trapped && (!we || sz < 4);
        exp_wr    = !trapped && we;
        lat       = trapped ? 1 : 1 + (exp_rd ? 1 + wait_cfg : 0) + (exp_wr ? 1 + wait_cfg : 0)
                              + ((exp_rd && exp_wr) ? 1 : 0);
        exp_rdata = (!we && !trapped) ? old_w : 32'h0;
        rd0 = n_rd;
        wr0 = n_wr;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_mask_i  = mask;
        req_wdata_i = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_we_i    = 1'($urandom_range(0, 1));
        req_addr_i  = $urandom;
        req_mask_i  = 3'($urandom_range(0, 7));
        req_wdata_i = $urandom;
        k = 1;
        while (!rsp_valid_o && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        check_val("latency", k, lat);
        check_val("rsp_rdata", rsp_rdata_o, exp_rdata);
        check_val("rsp_mask", rsp_mask_o, mask);
        check_val("rsp_offset", rsp_offset_o, eff);
        check_val("rsp_err", rsp_err_o, trapped);
        check_val("busy_in_resp", busy_o, 1);
        check_val("n_reads", n_rd - rd0, exp_rd);
        check_val("n_writes", n_wr - wr0, exp_wr);
        check_val("mem_word", mem[idx], exp_wr ? new_w : old_w);
        if (exp_wr) check_val("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
        if (exp_rd) check_val("rd_addr", last_rd_addr, {addr[31:2], 2'b00});
        @(negedge clk_i);
        check_val("rsp_one_cycle", rsp_valid_o, 0);
        check_val("rsp_rdata_hold", rsp_rdata_o, exp_rdata);
        check_val("rsp_offset_hold", rsp_offset_o, eff);
        check_val("idle_after_resp", busy_o, 0);
    endtask

    initial begin
        int          seen, busy_seen, wr0;
        logic [31:0] keep;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0;
        req_mask_i  = 3'b000;
        req_wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check_val("rst_ready", req_ready_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_mem_req", {mem_req_o, mem_we_o}, 0);
        check_val("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_mask_o, rsp_offset_o}, 0);
        check_val("rst_rsp_rdata", rsp_rdata_o, 0);
        check_val("rst_mem_bus", {mem_addr_o, mem_wdata_o}, 0);
        rst_i = 1'b0;
        #1;
        check_val("ready_after_rst", req_ready_o, 1);

        mem[32'h100 >> 2] = 32'hDEADBEEF;
        wait_cfg = 0;
        do_req(1'b0, 32'h100, 3'b011, 32'h0);
        check_val("tp_load_addr", last_rd_addr, 32'h100);
        check_val("tp_load_data", rsp_rdata_o, 32'hDEADBEEF);

        mem[32'h200 >> 2] = 32'h11223344;
        wait_cfg = 2;
        do_req(1'b1, 32'h203, 3'b000, 32'h000000AA);
        check_val("tp_sb_word", mem[32'h200 >> 2], 32'hAA223344);

        mem[32'h300 >> 2] = 32'h11223344;
        wait_cfg = 0;
        do_req(1'b1, 32'h302, 3'b001, 32'h0000BEEF);
        check_val("tp_sh_word", mem[32'h300 >> 2], 32'hBEEF3344);
        do_req(1'b1, 32'h300, 3'b011, 32'hCAFEF00D);
        check_val("tp_sw_word", mem[32'h300 >> 2], 32'hCAFEF00D);

        do_req(1'b0, 32'h401, 3'b101, 32'h0);

        // reset during a write wait: transaction is dropped, no response
        wait_cfg = 6;
        keep = mem[32'h500 >> 2];
        wr0  = n_wr;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h500;
        req_mask_i  = 3'b011;
        req_wdata_i = 32'h12345678;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_val("rst_pre_wr", {mem_req_o, mem_we_o}, 2'b11);
        rst_i = 1'b1;
        #1;
        check_val("ready_in_rst", req_ready_o, 0);
        @(negedge clk_i);
        check_val("rst_abort_req", mem_req_o, 0);
        check_val("rst_abort_busy", busy_o, 0);
        rst_i = 1'b0;
        #1;
        check_val("rst_abort_ready", req_ready_o, 1);
        seen      = 0;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen++;
            if (busy_o) busy_seen++;
        end
        check_val("rst_no_rsp", seen, 0);
        check_val("idle_ack_ignored", busy_seen, 0);
        check_val("rst_no_write", n_wr - wr0, 0);
        check_val("rst_mem_kept", mem[32'h500 >> 2], keep);

        for (int t = 0; t < 150; t++) begin
            logic [2:0] m;
            wait_cfg = $urandom_range(0, 2);
            m = 3'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), m, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
